// File: rtl/program_memory_loader.sv
// Streams a little-endian byte image (header word count, then words) into program memory.
// Optional PROGRAM_LOADER_CHECKSUM_EN adds a trailing 32-bit sum check before the CPU is released.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for Start after reset, bytes ignored
// S_HEADER  | collecting the 4-byte word count
// S_PAYLOAD | collecting the 4 bytes of the next instruction word
// S_WRITE   | single-cycle memory write strobe, byte intake paused
// S_CHECK   | collecting the 4-byte checksum (checksum build only)
// S_DONE    | image accepted, CPU released
// S_ERROR   | image rejected, CPU held
module program_memory_loader #(
  parameter int          MEMORY_DEPTH = 32,
  parameter int          DATA_WIDTH   = 32,
  parameter logic [31:0] BASE_ADDRESS = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [7:0]  ByteIn,
  input  logic        ByteValid,
  output logic        ByteReady,
  output logic        WriteEnable,
  output logic [31:0] WriteAddress,
  output logic [31:0] WriteData,
  output logic [7:0]  WordsWritten,
  output logic        CpuHold,
  output logic        Done,
  output logic        Error
);

  localparam logic [1:0] LAST_BYTE = 2'(DATA_WIDTH / 8 - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_PAYLOAD,
    S_WRITE,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  state_t      state;
  logic [1:0]  byte_idx;
  logic [23:0] byte_buf;
  logic [7:0]  word_total;
  logic        accept;
  logic        group_last;
  logic [31:0] group;

  // The fourth byte completes a group combinationally so it can be used on its accepting edge.
  assign accept     = ByteValid & ByteReady;
  assign group_last = accept && (byte_idx == LAST_BYTE);
  assign group      = {ByteIn, byte_buf};

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [31:0] running_sum;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      byte_idx     <= 2'd0;
      byte_buf     <= 24'd0;
      word_total   <= 8'd0;
      ByteReady    <= 1'b0;
      WriteEnable  <= 1'b0;
      WriteAddress <= BASE_ADDRESS;
      WriteData    <= 32'd0;
      WordsWritten <= 8'd0;
      CpuHold      <= 1'b1;
      Done         <= 1'b0;
      Error        <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      running_sum  <= 32'd0;
`endif
    end else begin
      WriteEnable <= 1'b0;

      if (accept) begin
        byte_idx <= byte_idx + 2'd1;
        case (byte_idx)
          2'd0:    byte_buf[7:0]   <= ByteIn;
          2'd1:    byte_buf[15:8]  <= ByteIn;
          2'd2:    byte_buf[23:16] <= ByteIn;
          default: ;
        endcase
      end

      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (Start) begin
            state        <= S_HEADER;
            ByteReady    <= 1'b1;
            byte_idx     <= 2'd0;
            WordsWritten <= 8'd0;
            CpuHold      <= 1'b1;
            Done         <= 1'b0;
            Error        <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            running_sum  <= 32'd0;
`endif
          end
        end

        S_HEADER: begin
          if (group_last) begin
            if (group == 32'd0 || group > 32'(MEMORY_DEPTH)) begin
              state     <= S_ERROR;
              ByteReady <= 1'b0;
              Error     <= 1'b1;
            end else begin
              state      <= S_PAYLOAD;
              word_total <= group[7:0];
            end
          end
        end

        S_PAYLOAD: begin
          if (group_last) begin
            state        <= S_WRITE;
            ByteReady    <= 1'b0;
            WriteEnable  <= 1'b1;
            WriteData    <= group;
            WriteAddress <= BASE_ADDRESS + {22'd0, WordsWritten, 2'b00};
          end
        end

        S_WRITE: begin
          WordsWritten <= WordsWritten + 8'd1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          running_sum  <= running_sum + WriteData;
`endif
          if (WordsWritten == word_total - 8'd1) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            state     <= S_CHECK;
            ByteReady <= 1'b1;
`else
            state     <= S_DONE;
            Done      <= 1'b1;
            CpuHold   <= 1'b0;
`endif
          end else begin
            state     <= S_PAYLOAD;
            ByteReady <= 1'b1;
          end
        end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
        S_CHECK: begin
          if (group_last) begin
            ByteReady <= 1'b0;
            if (group == running_sum) begin
              state   <= S_DONE;
              Done    <= 1'b1;
              CpuHold <= 1'b0;
            end else begin
              state <= S_ERROR;
              Error <= 1'b1;
            end
          end
        end
`endif

        default: begin
          state     <= S_IDLE;
          ByteReady <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_memory_loader.sv
// Bench for program_memory_loader: directed and randomized image loads checked against
// an image-level model (expected write list, final status) built from the stream rules.
module tb_program_memory_loader;
  localparam int          DEPTH = 32;
  localparam logic [31:0] BASE  = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic [7:0]  ByteIn;
  logic        ByteValid;
  logic        ByteReady;
  logic        WriteEnable;
  logic [31:0] WriteAddress;
  logic [31:0] WriteData;
  logic [7:0]  WordsWritten;
  logic        CpuHold;
  logic        Done;
  logic        Error;

  program_memory_loader #(
    .MEMORY_DEPTH(DEPTH),
    .DATA_WIDTH(32),
    .BASE_ADDRESS(BASE)
  ) dut (
    .clk(clk),
    .reset(reset),
    .Start(Start),
    .ByteIn(ByteIn),
    .ByteValid(ByteValid),
    .ByteReady(ByteReady),
    .WriteEnable(WriteEnable),
    .WriteAddress(WriteAddress),
    .WriteData(WriteData),
    .WordsWritten(WordsWritten),
    .CpuHold(CpuHold),
    .Done(Done),
    .Error(Error)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [31:0] payload[$];
  logic [31:0] cks;
  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];
  int cyc = 0;
  int last_acc_cyc = 0;
  int last_we_cyc = 0;
  int done_cyc = 0;
  int lat_bad = 0;
  int we_rdy_bad = 0;
  int rdy_low = 0;
  int rdy_low_we = 0;
  int hs_timeouts = 0;
  bit mon_en = 0;
  bit done_prev = 0;

  // Monitor: logs every write and the handshake/timing facts the tests inspect.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (WriteEnable === 1'b1) begin
      wa_q.push_back(WriteAddress);
      wd_q.push_back(WriteData);
      last_we_cyc = cyc;
      if (cyc != last_acc_cyc + 1) lat_bad = lat_bad + 1;
      if (ByteReady !== 1'b0) we_rdy_bad = we_rdy_bad + 1;
    end
    if (mon_en && ByteReady === 1'b0 && Done !== 1'b1 && Error !== 1'b1) begin
      rdy_low = rdy_low + 1;
      if (WriteEnable === 1'b1) rdy_low_we = rdy_low_we + 1;
    end
    if (Done === 1'b1 && !done_prev) done_cyc = cyc;
    done_prev = (Done === 1'b1);
  end

  task automatic do_reset();
    reset = 1'b1; Start = 1'b0; ByteValid = 1'b0; ByteIn = 8'h00;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 Start = 1'b1;
    @(posedge clk); #1 Start = 1'b0;
    mon_en = 1'b1;
  endtask

  // gap_mode: 0 back-to-back, 1 exactly one idle cycle after each byte, 2 random 0..2 idle cycles
  task automatic send_byte(input logic [7:0] b, input int gap_mode);
    int n = 0;
    bit got = 0;
    ByteIn = b;
    ByteValid = 1'b1;
    while (!got && n < 64) begin
      @(negedge clk);
      if (ByteReady === 1'b1) begin
        @(posedge clk);
        last_acc_cyc = cyc;
        #1 got = 1;
      end
      n++;
    end
    ByteValid = 1'b0;
    if (!got) hs_timeouts++;
    if (gap_mode == 1) begin
      @(posedge clk); #1;
    end else if (gap_mode == 2) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic run_load(input logic [31:0] n, input int gap_mode);
    int w = 0;
    pulse_start();
    for (int i = 0; i < 4; i++) send_byte(n[8*i +: 8], gap_mode);
    if (n != 0 && n <= DEPTH) begin
      foreach (payload[k]) for (int i = 0; i < 4; i++) send_byte(payload[k][8*i +: 8], gap_mode);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      for (int i = 0; i < 4; i++) send_byte(cks[8*i +: 8], gap_mode);
`endif
    end
    while (!(Done === 1'b1 || Error === 1'b1) && w < 20) begin
      @(negedge clk);
      w++;
    end
    @(negedge clk);
    mon_en = 1'b0;
  endtask

  function automatic logic [31:0] sum_of_payload();
    logic [31:0] s = 32'd0;
    foreach (payload[k]) s = s + payload[k];
    return s;
  endfunction

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    tests++; if (ByteReady !== 1'b0) begin fails++; $display("FAIL reset ByteReady got %b want 0", ByteReady); end
    tests++; if (WriteEnable !== 1'b0) begin fails++; $display("FAIL reset WriteEnable got %b want 0", WriteEnable); end
    tests++; if (WriteAddress !== BASE || WriteData !== 32'd0) begin fails++;
      $display("FAIL reset addr/data got %h/%h want %h/0", WriteAddress, WriteData, BASE); end
    tests++; if (WordsWritten !== 8'd0) begin fails++; $display("FAIL reset WordsWritten got %0d want 0", WordsWritten); end
    tests++; if ({CpuHold, Done, Error} !== 3'b100) begin fails++;
      $display("FAIL reset hold/done/err got %b want 100", {CpuHold, Done, Error}); end
    // reset and Start together: reset must win
    @(posedge clk); #1 reset = 1'b1; Start = 1'b1;
    @(posedge clk); #1 reset = 1'b0; Start = 1'b0;
    @(negedge clk);
    tests++; if (ByteReady !== 1'b0) begin fails++; $display("FAIL reset_vs_start ByteReady got %b want 0", ByteReady); end
  endtask

  task automatic test_basic();
    int base, lat0, rdy0, to0;
    do_reset();
    payload = '{32'h2008_0013, 32'h2009_0004};
    cks = sum_of_payload();
    base = wa_q.size(); lat0 = lat_bad; rdy0 = we_rdy_bad; to0 = hs_timeouts;
    run_load(32'd2, 0);
    tests++; if (hs_timeouts != to0) begin fails++; $display("FAIL basic handshake timeouts got %0d want 0", hs_timeouts - to0); end
    tests++; if (wa_q.size() - base != 2) begin fails++; $display("FAIL basic write count got %0d want 2", wa_q.size() - base); end
    tests++; if (wa_q.size() >= base + 1 && (wa_q[base] !== 32'h0040_0000 || wd_q[base] !== 32'h2008_0013)) begin fails++;
      $display("FAIL basic write0 got %h@%h want 20080013@00400000", wd_q[base], wa_q[base]); end
    tests++; if (wa_q.size() >= base + 2 && (wa_q[base+1] !== 32'h0040_0004 || wd_q[base+1] !== 32'h2009_0004)) begin fails++;
      $display("FAIL basic write1 got %h@%h want 20090004@00400004", wd_q[base+1], wa_q[base+1]); end
    tests++; if (WordsWritten !== 8'd2) begin fails++; $display("FAIL basic WordsWritten got %0d want 2", WordsWritten); end
    tests++; if ({CpuHold, Done, Error} !== 3'b010) begin fails++;
      $display("FAIL basic hold/done/err got %b want 010", {CpuHold, Done, Error}); end
    tests++; if (lat_bad != lat0) begin fails++; $display("FAIL basic write latency violations got %0d want 0", lat_bad - lat0); end
    tests++; if (we_rdy_bad != rdy0) begin fails++; $display("FAIL basic ByteReady during write got %0d want 0", we_rdy_bad - rdy0); end
`ifndef PROGRAM_LOADER_CHECKSUM_EN
    tests++; if (done_cyc != last_we_cyc + 1) begin fails++;
      $display("FAIL basic done timing got cycle %0d want %0d", done_cyc, last_we_cyc + 1); end
`endif
  endtask

  task automatic test_bad_header();
    int base;
    do_reset();
    base = wa_q.size();
    run_load(32'd33, 0);
    tests++; if (wa_q.size() != base) begin fails++; $display("FAIL oversize writes got %0d want 0", wa_q.size() - base); end
    tests++; if ({CpuHold, Done, Error} !== 3'b101) begin fails++;
      $display("FAIL oversize hold/done/err got %b want 101", {CpuHold, Done, Error}); end
    pulse_start();
    @(negedge clk);
    mon_en = 1'b0;
    tests++; if (Error !== 1'b0 || ByteReady !== 1'b1) begin fails++;
      $display("FAIL oversize restart err/rdy got %b%b want 01", Error, ByteReady); end
    do_reset();
    base = wa_q.size();
    run_load(32'd0, 0);
    tests++; if (wa_q.size() != base) begin fails++; $display("FAIL zero_header writes got %0d want 0", wa_q.size() - base); end
    tests++; if ({CpuHold, Done, Error} !== 3'b101) begin fails++;
      $display("FAIL zero_header hold/done/err got %b want 101", {CpuHold, Done, Error}); end
  endtask

  task automatic test_gapped();
    int base, r0, rw0;
    logic [31:0] a_ref, d_ref;
    do_reset();
    payload = '{$urandom()};
    cks = sum_of_payload();
    base = wa_q.size();
    run_load(32'd1, 0);
    a_ref = (wa_q.size() > base) ? wa_q[base] : 32'hx;
    d_ref = (wd_q.size() > base) ? wd_q[base] : 32'hx;
    tests++; if (a_ref !== BASE || d_ref !== payload[0]) begin fails++;
      $display("FAIL nogap write got %h@%h want %h@%h", d_ref, a_ref, payload[0], BASE); end
    do_reset();
    base = wa_q.size(); r0 = rdy_low; rw0 = rdy_low_we;
    run_load(32'd1, 1);
    tests++; if (wa_q.size() != base + 1 || wa_q[base] !== a_ref || wd_q[base] !== d_ref) begin fails++;
      $display("FAIL gapped write differs from gap-free (count %0d)", wa_q.size() - base); end
    tests++; if (rdy_low - r0 != 1 || rdy_low_we - rw0 != 1) begin fails++;
      $display("FAIL gapped ByteReady low cycles got %0d (with write %0d) want 1 (1)", rdy_low - r0, rdy_low_we - rw0); end
    tests++; if (Done !== 1'b1) begin fails++; $display("FAIL gapped Done got %b want 1", Done); end
  endtask

  task automatic test_reset_mid();
    int base, rdy_hi;
    do_reset();
    payload = '{$urandom(), $urandom(), $urandom()};
    cks = sum_of_payload();
    base = wa_q.size();
    pulse_start();
    for (int i = 0; i < 4; i++) send_byte(8'(i == 0 ? 3 : 0), 0);
    send_byte(payload[0][7:0], 0);
    send_byte(payload[0][15:8], 0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mon_en = 1'b0;
    tests++; if ({ByteReady, WriteEnable, CpuHold, Done, Error} !== 5'b00100 || WordsWritten !== 8'd0 ||
                 WriteAddress !== BASE || WriteData !== 32'd0) begin fails++;
      $display("FAIL reset_mid outputs rdy/we/hold/done/err %b ww %0d addr %h data %h",
               {ByteReady, WriteEnable, CpuHold, Done, Error}, WordsWritten, WriteAddress, WriteData); end
    reset = 1'b0;
    ByteValid = 1'b1; ByteIn = 8'hA5;
    rdy_hi = 0;
    repeat (6) begin @(negedge clk); if (ByteReady !== 1'b0) rdy_hi++; end
    ByteValid = 1'b0;
    tests++; if (rdy_hi != 0 || wa_q.size() != base) begin fails++;
      $display("FAIL reset_mid idle accepted: ready cycles %0d writes %0d want 0/0", rdy_hi, wa_q.size() - base); end
  endtask

  task automatic test_random();
    do_reset();
    for (int it = 0; it < 8; it++) begin
      logic [31:0] n;
      int base, exp_n, r;
      bit legal;
      r = $urandom_range(0, 9);
      if (it == 0) n = DEPTH;
      else if (r == 0) n = 0;
      else if (r == 1) n = 32'(DEPTH + 1 + $urandom_range(0, 200));
      else if (r == 2) n = 32'h0000_0100 + 32'($urandom_range(1, 4));
      else n = 32'($urandom_range(1, DEPTH));
      legal = (n >= 1 && n <= DEPTH);
      exp_n = legal ? int'(n) : 0;
      payload.delete();
      for (int k = 0; k < exp_n; k++) payload.push_back($urandom());
      cks = sum_of_payload();
      base = wa_q.size();
      run_load(n, 2);
      tests++; if (wa_q.size() - base != exp_n) begin fails++;
        $display("FAIL random[%0d] n=%0d write count got %0d want %0d", it, n, wa_q.size() - base, exp_n); end
      for (int i = 0; i < exp_n && base + i < wa_q.size(); i++) begin
        tests++;
        if (wa_q[base+i] !== BASE + 32'(4 * i) || wd_q[base+i] !== payload[i]) begin fails++;
          $display("FAIL random[%0d] word %0d got %h@%h want %h@%h", it, i, wd_q[base+i], wa_q[base+i],
                   payload[i], BASE + 32'(4 * i)); end
      end
      tests++; if (WordsWritten !== 8'(exp_n) || {CpuHold, Done, Error} !== (legal ? 3'b010 : 3'b101)) begin fails++;
        $display("FAIL random[%0d] n=%0d status ww %0d hde %b want ww %0d hde %b", it, n, WordsWritten,
                 {CpuHold, Done, Error}, exp_n, legal ? 3'b010 : 3'b101); end
    end
  endtask

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    int base;
    do_reset();
    payload = '{32'h0000_0001, 32'hFFFF_FFFF};
    cks = 32'h0000_0000;
    run_load(32'd2, 0);
    tests++; if ({CpuHold, Done, Error} !== 3'b010) begin fails++;
      $display("FAIL checksum_match hold/done/err got %b want 010", {CpuHold, Done, Error}); end
    cks = 32'h0000_0001;
    base = wa_q.size();
    run_load(32'd2, 0);
    tests++; if ({CpuHold, Done, Error} !== 3'b101) begin fails++;
      $display("FAIL checksum_mismatch hold/done/err got %b want 101", {CpuHold, Done, Error}); end
    tests++; if (wa_q.size() - base != 2) begin fails++;
      $display("FAIL checksum_mismatch writes got %0d want 2", wa_q.size() - base); end
  endtask
`endif

  initial begin
    reset = 1'b1; Start = 1'b0; ByteValid = 1'b0; ByteIn = 8'h00;
    test_reset();
    test_basic();
    test_bad_header();
    test_gapped();
    test_reset_mid();
    test_random();
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    tests++; if (hs_timeouts != 0) begin fails++; $display("FAIL handshake timeouts got %0d want 0", hs_timeouts); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
